// File: rtl/uart_pkg.sv
// Shared UART constants and types used by uart_rx, uart_tx and the RX/TX byte FIFOs.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 87;
    localparam int UART_FIFO_ADDR_W  = 4;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the RX FIFO and its consumer.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int ADDR_W = UART_FIFO_ADDR_W,
    parameter int DATA_W = UART_DATA_W
);

    logic              i_RX_DV;
    logic [DATA_W-1:0] i_RX_Data;
    logic [DATA_W-1:0] o_Data;
    logic              o_Valid;
    logic              i_Ready;
    logic [ADDR_W:0]   o_Count;
    logic              o_Full;
    logic              o_Empty;
    logic              o_Overflow;
    logic              i_Clear_Overflow;

    modport slave (
        input  i_RX_DV, i_RX_Data, i_Ready, i_Clear_Overflow,
        output o_Data, o_Valid, o_Count, o_Full, o_Empty, o_Overflow
    );

    modport master (
        output i_RX_DV, i_RX_Data, i_Ready, i_Clear_Overflow,
        input  o_Data, o_Valid, o_Count, o_Full, o_Empty, o_Overflow
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int ADDR_W = UART_FIFO_ADDR_W,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              i_Clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage is deliberately not reset; pointers define which entries are live.
    always_ff @(posedge i_Clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with fill level and sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_W = UART_FIFO_ADDR_W,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    uart_rx_fifo_if.slave        bus
);

    localparam int unsigned      DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W+1)'(1'b1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1'b1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              full_r;
    logic              empty_r;
    logic              overflow_r;

    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              mem_we_s;
    logic [ADDR_W:0]   count_next_s;
    logic [DATA_W-1:0] rdata_s;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign pop_s    = !empty_r && bus.i_Ready;
    assign push_s   = bus.i_RX_DV && (!full_r || pop_s);
    assign drop_s   = bus.i_RX_DV && full_r && !pop_s;
    assign mem_we_s = push_s && !i_Reset;

    // Next fill level from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, level and flags; flags are derived from the next level so they track o_Count.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {(ADDR_W+1){1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_CNT);
            empty_r <= (count_next_s == {(ADDR_W+1){1'b0}});
            // A fresh drop outranks a simultaneous clear.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.i_Clear_Overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    uart_fifo_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .i_Clock (i_Clock),
        .we      (mem_we_s),
        .waddr   (wr_ptr_r),
        .wdata   (bus.i_RX_Data),
        .raddr   (rd_ptr_r),
        .rdata   (rdata_s)
    );

    assign bus.o_Data     = rdata_s;
    assign bus.o_Valid    = !empty_r;
    assign bus.o_Count    = count_r;
    assign bus.o_Full     = full_r;
    assign bus.o_Empty    = empty_r;
    assign bus.o_Overflow = overflow_r;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: handshake, full/overflow, wrap and reset cases.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx_fifo_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    uart_rx_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Data = b;
        tick();
        bus.i_RX_DV   = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.i_RX_DV          = 1'b1;
        bus.i_RX_Data        = 8'h77;
        bus.i_Ready          = 1'b0;
        bus.i_Clear_Overflow = 1'b0;
        tick();
        tick();
        rst         = 1'b0;
        bus.i_RX_DV = 1'b0;

        // 1 reset state, strobe during reset ignored
        chk("rst_empty", 32'(bus.o_Empty), 32'd1);
        chk("rst_valid", 32'(bus.o_Valid), 32'd0);
        chk("rst_count", 32'(bus.o_Count), 32'd0);
        chk("rst_ovf",   32'(bus.o_Overflow), 32'd0);
        chk("rst_full",  32'(bus.o_Full), 32'd0);

        // 2 single byte, fall-through latency
        push(8'hA5);
        chk("one_valid", 32'(bus.o_Valid), 32'd1);
        chk("one_data",  32'(bus.o_Data), 32'hA5);
        chk("one_count", 32'(bus.o_Count), 32'd1);
        bus.i_Ready = 1'b1;
        tick();
        bus.i_Ready = 1'b0;
        chk("one_empty", 32'(bus.o_Empty), 32'd1);

        // 3 fill, overflow drop, ordered drain
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full",  32'(bus.o_Full), 32'd1);
        chk("fill_count", 32'(bus.o_Count), 32'd16);
        push(8'h10);
        chk("drop_ovf",   32'(bus.o_Overflow), 32'd1);
        chk("drop_count", 32'(bus.o_Count), 32'd16);
        bus.i_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", 32'(bus.o_Valid), 32'd1);
            chk("drain_data",  32'(bus.o_Data), 32'(i));
            tick();
        end
        bus.i_Ready = 1'b0;
        chk("drain_empty", 32'(bus.o_Empty), 32'd1);
        bus.i_Clear_Overflow = 1'b1;
        tick();
        bus.i_Clear_Overflow = 1'b0;
        chk("clr_ovf", 32'(bus.o_Overflow), 32'd0);

        // 4 full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        bus.i_Ready = 1'b1;
        push(8'h55);
        bus.i_Ready = 1'b0;
        chk("fpp_count", 32'(bus.o_Count), 32'd16);
        chk("fpp_ovf",   32'(bus.o_Overflow), 32'd0);
        chk("fpp_full",  32'(bus.o_Full), 32'd1);
        bus.i_Ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("fpp_data", 32'(bus.o_Data), 32'(8'h20 + i));
            tick();
        end
        chk("fpp_last", 32'(bus.o_Data), 32'h55);
        tick();
        chk("fpp_empty", 32'(bus.o_Empty), 32'd1);

        // 5 streaming with wrap; first cycle is empty+push+pop (pop ignored)
        for (int i = 0; i < 40; i++) begin
            if (i > 0) chk("wrap_data", 32'(bus.o_Data), 32'(8'h80 + i - 1));
            bus.i_RX_DV   = 1'b1;
            bus.i_RX_Data = 8'(8'h80 + i);
            tick();
            chk("wrap_count", 32'(bus.o_Count), 32'd1);
        end
        bus.i_RX_DV = 1'b0;
        chk("wrap_tail", 32'(bus.o_Data), 32'(8'h80 + 39));
        tick();
        bus.i_Ready = 1'b0;
        chk("wrap_empty", 32'(bus.o_Empty), 32'd1);

        // 6 clear vs drop priority, clear alone, reset with stale data
        for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
        chk("ovf_set", 32'(bus.o_Overflow), 32'd1);
        bus.i_Clear_Overflow = 1'b1;
        push(8'hEE);
        chk("ovf_set_wins", 32'(bus.o_Overflow), 32'd1);
        tick();
        bus.i_Clear_Overflow = 1'b0;
        chk("ovf_cleared", 32'(bus.o_Overflow), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
        chk("pre_rst_count", 32'(bus.o_Count), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_empty", 32'(bus.o_Empty), 32'd1);
        chk("mid_rst_count", 32'(bus.o_Count), 32'd0);
        chk("mid_rst_valid", 32'(bus.o_Valid), 32'd0);
        push(8'h99);
        chk("post_rst_data",  32'(bus.o_Data), 32'h99);
        chk("post_rst_count", 32'(bus.o_Count), 32'd1);
        bus.i_Ready = 1'b1;
        tick();
        bus.i_Ready = 1'b0;
        chk("post_rst_empty", 32'(bus.o_Empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
